pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 52 +++++
 tb/tb_pipe_stage_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register with optional skid entry, stall, flush and bubble injection
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter bit SKID = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [7:0]       flush_drops
);
  logic [WIDTH-1:0] main_q, skid_q;
  logic main_v, skid_v, out_fire, in_fire;
  logic [8:0] drops_sum;
  always_comb begin
    out_valid = main_v & ~flush & ~reset;
    out_fire  = out_valid & out_ready & ~stall;
    in_ready  = ~flush & ~reset & (SKID ? ~skid_v : (~main_v | out_fire));
    in_fire   = in_valid & in_ready;
    out_data  = out_valid ? main_q : BUBBLE;
    occupancy = {1'b0, main_v} + {1'b0, skid_v};
    drops_sum = {1'b0, flush_drops} + {7'd0, occupancy};
  end
  always_ff @(posedge clock)
    if (reset || flush) begin
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      main_v      <= 1'b0;
      skid_v      <= 1'b0;
      flush_drops <= reset ? 8'd0 : (drops_sum[8] ? 8'hFF : drops_sum[7:0]);
    end else if (out_fire) begin
      main_q <= skid_v ? skid_q : (in_fire ? in_data : BUBBLE);
      main_v <= skid_v | in_fire;
      skid_v <= 1'b0;
    end else if (in_fire) begin
      if (SKID && main_v) begin
        skid_q <= in_data;
        skid_v <= 1'b1;
      end else begin
        main_q <= in_data;
        main_v <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg with SKID=1 and SKID=0 instances
module tb_pipe_stage_reg;
  localparam logic [15:0] BUBBLE = 16'hDEAD;
  logic clock = 1'b0, reset = 1'b1, stall = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [15:0] in_data = '0, out_data;
  logic [1:0] occupancy;
  logic [7:0] flush_drops;
  logic in_valid0 = 1'b0, out_ready0 = 1'b0, in_ready0, out_valid0;
  logic [15:0] in_data0 = '0, out_data0;
  logic [1:0] occupancy0;
  logic [7:0] flush_drops0;
  int n_vec = 0, n_err = 0;
  logic [15:0] q[$], q0[$];
  int drops = 0, drops0 = 0, occ_max = 0;
  logic track = 1'b0, rdy_low = 1'b0, ev, er, ev0, er0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.WIDTH(16), .BUBBLE(BUBBLE), .SKID(1'b1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .stall(stall), .flush(flush),
    .occupancy(occupancy), .flush_drops(flush_drops));

  pipe_stage_reg #(.WIDTH(16), .BUBBLE(BUBBLE), .SKID(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .stall(stall), .flush(flush),
    .occupancy(occupancy0), .flush_drops(flush_drops0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  // Reference model: FIFO queue of accepted payloads plus a saturating drop counter
  always @(negedge clock) begin
    ev = q.size() > 0 && !flush && !reset;
    er = q.size() < 2 && !flush && !reset;
    chk("occupancy", occupancy, q.size());
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    chk("out_data", out_data, ev ? q[0] : BUBBLE);
    chk("flush_drops", flush_drops, drops);
    if (track) begin
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      if (!in_ready) rdy_low = 1'b1;
    end
    if (reset) begin
      q.delete();
      drops = 0;
    end else if (flush) begin
      drops = (drops + q.size() > 255) ? 255 : drops + q.size();
      q.delete();
    end else begin
      if (ev && out_ready && !stall) void'(q.pop_front());
      if (er && in_valid) q.push_back(in_data);
    end
  end

  always @(negedge clock) begin
    ev0 = q0.size() > 0 && !flush && !reset;
    er0 = (q0.size() == 0 || (ev0 && out_ready0 && !stall)) && !flush && !reset;
    chk("s0_occupancy", occupancy0, q0.size());
    chk("s0_out_valid", out_valid0, ev0);
    chk("s0_in_ready", in_ready0, er0);
    chk("s0_out_data", out_data0, ev0 ? q0[0] : BUBBLE);
    chk("s0_flush_drops", flush_drops0, drops0);
    if (reset) begin
      q0.delete();
      drops0 = 0;
    end else if (flush) begin
      drops0 = (drops0 + q0.size() > 255) ? 255 : drops0 + q0.size();
      q0.delete();
    end else begin
      if (ev0 && out_ready0 && !stall) void'(q0.pop_front());
      if (er0 && in_valid0) q0.push_back(in_data0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic fired;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_in_ready0", in_ready0, 1);
    @(posedge clock);
    #1;
    // stream 1..8 at full rate
    out_ready = 1'b1;
    track = 1'b1;
    for (int i = 1; i <= 8; i++) send(16'(i));
    repeat (3) tick();
    track = 1'b0;
    chk("stream_occ_max", occ_max, 1);
    chk("stream_rdy_low", rdy_low, 0);
    // backpressure A,B,C
    in_valid = 1'b1;
    in_data = 16'h00A1;
    tick();
    in_data = 16'h00B2;
    out_ready = 1'b0;
    tick();
    in_data = 16'h00C3;
    @(negedge clock);
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    tick();
    out_ready = 1'b1;
    send(16'h00C3);
    repeat (4) tick();
    // flush with two entries, repeated to saturation
    out_ready = 1'b0;
    for (int r = 0; r < 130; r++) begin
      send(16'(16'h0200 + 2 * r));
      send(16'(16'h0201 + 2 * r));
      flush = 1'b1;
      in_valid = 1'b1;
      in_data = 16'h03FF;
      @(negedge clock);
      if (r == 0) begin
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 0);
      end
      @(posedge clock);
      #1;
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      if (r == 0) begin
        chk("flush_occ", occupancy, 0);
        chk("flush_out_data", out_data, BUBBLE);
        chk("flush_drops_2", flush_drops, 2);
      end
      @(posedge clock);
      #1;
    end
    chk("flush_sat", flush_drops, 255);
    // stall holds the head while the skid fills
    send(16'h0055);
    stall = 1'b1;
    out_ready = 1'b1;
    send(16'h0066);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_data", out_data, 16'h0055);
      chk("stall_occ", occupancy, 2);
      @(posedge clock);
      #1;
    end
    stall = 1'b0;
    repeat (4) tick();
    // SKID=0: combinational ready and same-cycle replace
    in_valid0 = 1'b1;
    in_data0 = 16'h0500;
    for (int i = 0; i < 16; i++) begin
      out_ready0 = (i % 3) != 0;
      stall = (i % 5) == 4;
      @(negedge clock);
      fired = in_ready0;
      if (occupancy0 == 2'd1) chk("s0_rdy_comb", in_ready0, out_ready0 & ~stall);
      @(posedge clock);
      #1;
      if (fired) in_data0 = in_data0 + 16'd1;
    end
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    stall = 1'b0;
    repeat (3) tick();
    // reset mid-operation with flush and drops=7
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      send(16'(16'h0700 + r));
      send(16'(16'h0710 + r));
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    send(16'h0720);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send(16'h0731);
    send(16'h0732);
    @(negedge clock);
    chk("pre_rst_drops", flush_drops, 7);
    chk("pre_rst_occ", occupancy, 2);
    @(posedge clock);
    #1;
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_drops", flush_drops, 0);
    chk("mid_rst_data", out_data, BUBBLE);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clock);
    #1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
